// File: rtl/save_to_bram_stream_pkg.sv
// Shared types and sizing for the BRAM output stream saver.
// State encoding, default geometry and index-width helper.
package save_to_bram_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SERIAL,
    S_DONE
  } state_e;

  localparam int NUM_CH_DEF = 8;
  localparam int LANES_DEF  = 4;
  localparam int BYTES_PER_VEC = NUM_CH_DEF * LANES_DEF;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BYTE_IDX_W = idx_w(BYTES_PER_VEC);
  localparam int CH_IDX_W   = idx_w(NUM_CH_DEF);

endpackage

// File: rtl/bram_ch_addr_gen.sv
// Per-channel base/pointer bank; addr = base[sel] + ptr[sel].
// Ports: load (sample base, clear ptrs), sel/inc (bump ptr), addr.
module bram_ch_addr_gen
  import save_to_bram_stream_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int ADDR_W = 18,
  localparam int CH_W = idx_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [NUM_CH*ADDR_W-1:0] base,
  input  logic [CH_W-1:0]          sel,
  input  logic                     inc,
  output logic [ADDR_W-1:0]        addr
);

  logic [ADDR_W-1:0] base_q [NUM_CH];
  logic [ADDR_W-1:0] ptr_q  [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        base_q[k] <= '0;
        ptr_q[k]  <= '0;
      end
    end else if (load) begin
      for (int k = 0; k < NUM_CH; k++) begin
        base_q[k] <= base[k*ADDR_W +: ADDR_W];
        ptr_q[k]  <= '0;
      end
    end else if (inc) begin
      ptr_q[sel] <= ptr_q[sel] + 1'b1;
    end
  end

  // modulo 2^ADDR_W, wrap is intentional
  assign addr = base_q[sel] + ptr_q[sel];

endmodule

// File: rtl/save_to_bram_stream.sv
// Serializes NUM_CH x LANES byte vectors into per-channel BRAM regions.
// Ports: start/num_vectors/base_addr, in_valid/in_ready/data_in, sram_*, busy, done.
module save_to_bram_stream
  import save_to_bram_stream_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 18,
  parameter int CNT_W  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [CNT_W-1:0]                num_vectors,
  input  logic [NUM_CH*ADDR_W-1:0]        base_addr,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_CH*LANES*DATA_W-1:0]  data_in,
  input  logic [ADDR_W-1:0]               user_addr,
  output logic [ADDR_W-1:0]               sram_addr,
  output logic [DATA_W-1:0]               sram_din,
  output logic                            sram_en,
  output logic                            sram_we,
  output logic                            busy,
  output logic                            done
);

  localparam int CH_W = idx_w(NUM_CH);
  localparam int LN_W = idx_w(LANES);

  state_e state_q, state_d;

  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  vec_q;
  logic [CH_W-1:0]   ch_q;
  logic [LN_W-1:0]   lane_q;
  logic [DATA_W-1:0] hold_q [NUM_CH][LANES];

  logic              load;
  logic              accept;
  logic              issue;
  logic              ch_last;
  logic              last_byte;
  logic [ADDR_W-1:0] gen_addr;

  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;

  assign load      = (state_q == S_IDLE) && start;
  assign accept    = (state_q == S_WAIT) && in_valid;
  assign issue     = (state_q == S_SERIAL);
  assign ch_last   = (ch_q == CH_W'(NUM_CH - 1));
  assign last_byte = issue && ch_last &&
                     (lane_q == LN_W'(LANES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (start)
          state_d = (num_vectors == '0) ? S_DONE : S_WAIT;
      S_WAIT:
        if (in_valid) state_d = S_SERIAL;
      S_SERIAL:
        if (last_byte)
          state_d = (vec_q == num_q) ? S_DONE : S_WAIT;
      // hold until the final write has left the port
      S_DONE:
        if (!wr_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q  <= '0;
      vec_q  <= '0;
      ch_q   <= '0;
      lane_q <= '0;
    end else if (load) begin
      num_q  <= num_vectors;
      vec_q  <= '0;
      ch_q   <= '0;
      lane_q <= '0;
    end else if (accept) begin
      vec_q  <= vec_q + 1'b1;
      ch_q   <= '0;
      lane_q <= '0;
    end else if (issue) begin
      if (ch_last) begin
        ch_q   <= '0;
        lane_q <= lane_q + 1'b1;
      end else begin
        ch_q   <= ch_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NUM_CH; k++)
        for (int j = 0; j < LANES; j++)
          hold_q[k][j] <= data_in[(k*LANES+j)*DATA_W +: DATA_W];
    end
  end

  bram_ch_addr_gen #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .base  (base_addr),
    .sel   (ch_q),
    .inc   (issue),
    .addr  (gen_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      wr_q <= issue;
      if (issue) begin
        addr_q <= gen_addr;
        din_q  <= hold_q[ch_q][lane_q];
      end
    end
  end

  // wr_q steers the port; user reads see user_addr with no delay
  assign sram_addr = wr_q ? addr_q : user_addr;
  assign sram_din  = din_q;
  assign sram_we   = wr_q;
  assign sram_en   = 1'b1;
  assign in_ready  = (state_q == S_WAIT);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE) && !wr_q;

endmodule

// File: tb/tb_save_to_bram_stream.sv
// Randomized bench for save_to_bram_stream against a frame-level model.
// Expected write lists are built from vector/lane/channel arithmetic.
module tb_save_to_bram_stream;

  localparam int NCH = 8;
  localparam int LN  = 4;
  localparam int DW  = 8;
  localparam int AW  = 18;
  localparam int CW  = 16;
  localparam int VW  = NCH * LN * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] num_vectors;
  logic [NCH*AW-1:0] base_addr;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] data_in;
  logic [AW-1:0] user_addr;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic          sram_en;
  logic          sram_we;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  save_to_bram_stream #(
    .NUM_CH (NCH),
    .LANES  (LN),
    .DATA_W (DW),
    .ADDR_W (AW),
    .CNT_W  (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_vectors (num_vectors),
    .base_addr   (base_addr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_in     (data_in),
    .user_addr   (user_addr),
    .sram_addr   (sram_addr),
    .sram_din    (sram_din),
    .sram_en     (sram_en),
    .sram_we     (sram_we),
    .busy        (busy),
    .done        (done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int a;
    int d;
    int c;
  } wr_t;

  int  cyc = 0;
  wr_t wq[$];
  int  done_c[$];
  int  acc_c[$];
  int  rdy_n, busy_n;
  bit  gap_flag = 1'b0;
  int  gap_n, gap_wr, gap_bad;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sram_we === 1'b1)
      wq.push_back('{int'(sram_addr), int'(sram_din), cyc});
    if (done === 1'b1) done_c.push_back(cyc);
    if (in_ready && in_valid) acc_c.push_back(cyc);
    if (in_ready) rdy_n++;
    if (busy) busy_n++;
    if (gap_flag) begin
      gap_n++;
      if (sram_we) gap_wr++;
      else if (sram_addr !== user_addr) gap_bad++;
    end
  end

  logic [AW-1:0] bases [NCH];
  logic [VW-1:0] vecs[$];

  task automatic clear_mon();
    wq.delete();
    done_c.delete();
    acc_c.delete();
    rdy_n = 0;
    busy_n = 0;
    gap_n = 0;
    gap_wr = 0;
    gap_bad = 0;
  endtask

  task automatic rand_vecs(input int nv);
    logic [VW-1:0] t;
    vecs.delete();
    for (int v = 0; v < nv; v++) begin
      for (int w = 0; w < VW/32; w++) t[w*32 +: 32] = $urandom;
      vecs.push_back(t);
    end
  endtask

  task automatic rand_bases();
    for (int k = 0; k < NCH; k++) bases[k] = AW'($urandom);
  endtask

  task automatic start_frame(input int nv);
    clear_mon();
    for (int k = 0; k < NCH; k++) base_addr[k*AW +: AW] = bases[k];
    @(negedge clk);
    num_vectors = CW'(nv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_vec(input logic [VW-1:0] vec, input bit stall);
    int k;
    if (stall) begin
      in_valid = 1'b0;
      k = 0;
      while (!in_ready && k < 200) begin
        @(negedge clk);
        k++;
      end
      @(posedge clk);
      #1 gap_flag = 1'b1;
      repeat (10) @(posedge clk);
      #1 gap_flag = 1'b0;
    end
    in_valid = 1'b1;
    data_in = vec;
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int k = 0;
    while (done_c.size() == 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", done_c.size() > 0, 1);
    repeat (5) @(negedge clk);
  endtask

  task automatic run_frame(input int nv, input bit stall);
    start_frame(nv);
    for (int v = 0; v < nv; v++) send_vec(vecs[v], stall && v > 0);
    in_valid = 1'b0;
    wait_done();
  endtask

  task automatic check_frame(input string tag, input int nv);
    int i = 0;
    int bad = 0;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    check({tag, "_nwr"}, wq.size(), nv * NCH * LN);
    for (int v = 0; v < nv; v++)
      for (int l = 0; l < LN; l++)
        for (int c = 0; c < NCH; c++) begin
          ea = bases[c] + AW'(v * LN + l);
          ed = vecs[v][(c*LN + l)*DW +: DW];
          if (i < wq.size()) begin
            if (wq[i].a != int'(ea) || wq[i].d != int'(ed)) begin
              if (bad < 4)
                check({tag, "_wr"}, {wq[i].a, wq[i].d}, {int'(ea), int'(ed)});
              bad++;
            end
          end
          i++;
        end
    check({tag, "_badwr"}, bad, 0);
    check({tag, "_ndone"}, done_c.size(), 1);
    if (wq.size() > 0 && done_c.size() > 0)
      check({tag, "_done_t"}, done_c[0], wq[$].c + 1);
    if (wq.size() > 0 && acc_c.size() > 0)
      check({tag, "_first_t"}, wq[0].c, acc_c[0] + 2);
  endtask

  initial begin
    logic [VW-1:0] t;
    int sc, bad, k;

    rst_n = 1'b0;
    start = 1'b0;
    num_vectors = '0;
    base_addr = '0;
    in_valid = 1'b0;
    data_in = '0;
    user_addr = 18'h155;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_we", sram_we, 0);
    check("rst_en", sram_en, 1);
    check("rst_din", sram_din, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", sram_addr, 18'h155);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int c = 0; c < NCH; c++) bases[c] = AW'(c * 256);
    for (int c = 0; c < NCH; c++)
      for (int l = 0; l < LN; l++) t[(c*LN+l)*DW +: DW] = DW'(16*c + l);
    vecs.delete();
    vecs.push_back(t);
    run_frame(1, 1'b0);
    check_frame("pat", 1);
    if (wq.size() == 32) begin
      check("pat_w0", {wq[0].a, wq[0].d}, {32'd0, 32'h00});
      check("pat_w1", {wq[1].a, wq[1].d}, {32'd256, 32'h10});
      check("pat_w7", {wq[7].a, wq[7].d}, {32'd1792, 32'h70});
      check("pat_w8", {wq[8].a, wq[8].d}, {32'd1, 32'h01});
      check("pat_w31", {wq[31].a, wq[31].d}, {32'd1795, 32'h73});
    end

    rand_bases();
    rand_vecs(25);
    run_frame(25, 1'b0);
    check_frame("cont", 25);
    check("cont_rdy", rdy_n, 25);
    check("cont_nacc", acc_c.size(), 25);
    bad = 0;
    for (int i = 1; i < acc_c.size(); i++)
      if (acc_c[i] - acc_c[i-1] != 33) bad++;
    check("cont_period", bad, 0);

    rand_bases();
    rand_vecs(4);
    run_frame(4, 1'b1);
    check_frame("stall", 4);
    check("stall_gapn", gap_n, 30);
    check("stall_gapwr", gap_wr, 0);
    check("stall_uaddr", gap_bad, 0);

    rand_bases();
    bases[0] = 18'h3FFFE;
    rand_vecs(1);
    run_frame(1, 1'b0);
    check_frame("wrap", 1);
    if (wq.size() == 32) begin
      check("wrap_l0", wq[0].a, 18'h3FFFE);
      check("wrap_l1", wq[8].a, 18'h3FFFF);
      check("wrap_l2", wq[16].a, 18'h00000);
      check("wrap_l3", wq[24].a, 18'h00001);
    end

    rand_bases();
    rand_vecs(3);
    start_frame(3);
    send_vec(vecs[0], 1'b0);
    send_vec(vecs[1], 1'b0);
    in_valid = 1'b0;
    k = 0;
    while (wq.size() < 42 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("rst_reach", wq.size() >= 42, 1);
    rst_n = 1'b0;
    #1;
    check("mid_we", sram_we, 0);
    check("mid_busy", busy, 0);
    check("mid_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("mid_nodone", done_c.size(), 0);
    rand_vecs(1);
    run_frame(1, 1'b0);
    check_frame("after_rst", 1);

    clear_mon();
    @(negedge clk);
    num_vectors = '0;
    start = 1'b1;
    sc = cyc;
    @(negedge clk);
    num_vectors = 16'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("zero_nwr", wq.size(), 0);
    check("zero_ndone", done_c.size(), 1);
    if (done_c.size() > 0) check("zero_done_t", done_c[0], sc + 1);
    check("zero_busy", busy_n, 1);

    for (int r = 0; r < 3; r++) begin
      int nv = $urandom_range(1, 3);
      rand_bases();
      rand_vecs(nv);
      run_frame(nv, 1'($urandom_range(0, 1)));
      check_frame("rnd", nv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/save_to_bram_stream.md
Name: save_to_bram_stream

Overview:
- Parametrised successor of the systolic-output BRAM saver.
- Accepts one requantized output vector per handshake, NUM_CH channels x LANES bytes, and serializes it into single-byte BRAM writes. Each channel has its own base address and write pointer.
- Counts vectors per frame, pulses done, then returns the BRAM port to the user read path.
- Sits between the requantization block and the activation BRAM.

Parameters:
- NUM_CH, 8, number of systolic channels per input vector.
- LANES, 4, bytes per channel per vector.
- DATA_W, 8, bits per byte lane.
- ADDR_W, 18, BRAM address width.
- CNT_W, 16, width of the frame vector counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that arms a frame; ignored unless IDLE.
- num_vectors  in  CNT_W  vectors per frame (IMAGE_WIDTH*IMAGE_HEIGHT), sampled on start.
- base_addr  in  NUM_CH*ADDR_W  per-channel start address; ch k at [k*ADDR_W +: ADDR_W]; sampled on start.
- in_valid  in  1  data_in valid.
- in_ready  out  1  block can accept a vector this cycle.
- data_in  in  NUM_CH*LANES*DATA_W  ch k lane j at [(k*LANES+j)*DATA_W +: DATA_W].
- user_addr  in  ADDR_W  user read address, used when not busy.
- sram_addr  out  ADDR_W  BRAM address.
- sram_din  out  DATA_W  BRAM write data.
- sram_en  out  1  BRAM enable.
- sram_we  out  1  BRAM write enable.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last byte of the frame is written.

Behaviour:
- Reset values:
  - Outputs: in_ready=0, sram_we=0, sram_en=1, sram_din=0, busy=0, done=0.
  - Internals: all pointers 0, state=IDLE.
- States:
  - IDLE: busy=0, in_ready=0.
  - IDLE -> WAIT on start. If num_vectors==0, go to DONE instead.
  - WAIT: in_ready=1.
  - WAIT -> SERIAL when in_valid&in_ready; the whole data_in is captured into a holding register.
  - SERIAL: emits one byte per cycle for NUM_CH*LANES cycles, in_ready=0.
  - SERIAL -> WAIT after the last byte, or -> DONE if this was vector num_vectors.
  - DONE: done=1 for exactly 1 cycle, then -> IDLE.
- Byte order is lane-major: lane0 ch0..ch(NUM_CH-1), then lane1 ch0.., up to lane(LANES-1) ch(NUM_CH-1).
- Write address is base_addr[ch] + ptr[ch]. ptr[ch] increments by 1 after each byte of that channel, so each channel gets a contiguous region of num_vectors*LANES bytes.
- Address sum is ADDR_W bits, modulo 2^ADDR_W; wrap is silent with no error.
- Write timing: sram_en, sram_we, sram_addr and sram_din are registered. A byte issued in SERIAL cycle n appears on the port in cycle n+1 with we=1.
- Outside writes: we=0, en=1, and sram_addr=user_addr combinationally. The mux select is a register that is high only on write cycles, so the user path has 0-cycle address latency.
- Frame latency: the first write occurs 2 cycles after the accepting handshake. done pulses 1 cycle after the final write cycle.
- Boundary and ignore rules:
  - start while busy is ignored.
  - in_valid outside WAIT is ignored; no backpressure loss, because the upstream holds in_valid until in_ready.
- rst_n asserted mid-frame:
  - Immediately clears state, pointers, we and busy.
  - A partial frame is abandoned, and no done pulse is produced.
- Pointers clear on every accepted start. Base addresses are not re-sampled mid-frame.

Decomposition:
- Shared package holds:
  - State enum (IDLE, WAIT, SERIAL, DONE).
  - localparam BYTES_PER_VEC = NUM_CH*LANES.
  - $clog2-derived widths for the byte index and channel index.
- One sub-module, bram_ch_addr_gen: per-channel base register and pointer array with a select/increment interface. It returns base+ptr for the selected channel.

Test Plan:
- NUM_CH=8, LANES=4, num_vectors=1, base_addr[k]=k*256, data_in byte(k,j)=16*k+j:
  - Expect 32 writes in lane-major order: (addr 0, 0x00), (256, 0x10) .. (1792, 0x70), (1, 0x01) .. last (1795, 0x73).
  - done follows 1 cycle after the last write.
- num_vectors=25, in_valid continuously high:
  - Expect 800 writes.
  - Channel 3 addresses run base+0..99 contiguous.
  - in_ready high for 1 cycle in every 33.
  - One done pulse.
- Upstream stalls (in_valid low 10 cycles between vectors):
  - No writes during the gap.
  - sram_addr tracks user_addr=0x155 during the gap.
  - Pointers continue correctly after the gap.
- Wrap case, base_addr[0]=2^18-2, num_vectors=1:
  - ch0 writes go to 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
- rst_n pulled low at byte 10 of vector 2:
  - we drops immediately; busy=0; no done.
  - A new start with num_vectors=1 writes from base+0.
- start with num_vectors=0:
  - No writes; done 1 cycle after start (IDLE -> DONE); busy high for exactly that cycle.
  - A second start while busy is ignored.
